f_fetch_ctrl: RTL
=================

F_FETCH_CTRL -- requirements
Module: f_fetch_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have PC_F, input, 32 bits: current fetch PC from the instruction fetch unit.
REQ-004 SHALL have stall, input, 1 bit: hazard-unit freeze request for the F stage.
REQ-005 SHALL have br_valid, input, 1 bit: D-stage redirect strobe (taken branch, j, jal or jr).
REQ-006 SHALL have br_target, input, 32 bits: redirect address for br_valid.
REQ-007 SHALL have exc_req, input, 1 bit: exception redirect request; this port exists only with FETCH_EXC_EN.
REQ-008 SHALL have NPC, output, 32 bits: next PC driven to the fetch unit.
REQ-009 SHALL have WE, output, 1 bit: PC write enable to the fetch unit.
REQ-010 SHALL have pend_valid, output, 1 bit: a redirect is buffered.
REQ-011 SHALL have fetch_cnt, output, 32 bits: count of PC advances.

Function
REQ-012 SHALL implement a 2-state FSM: RUN (no buffered redirect) and PEND (redirect buffered in a 32-bit pend_target register).
REQ-013 SHALL, in RUN with stall=1 and br_valid=1, capture {br_target[31:2],2'b00} into pend_target and go to PEND next cycle.
REQ-014 SHALL, in PEND with stall=1 and br_valid=1, overwrite pend_target with the new target (newest wins) and stay in PEND.
REQ-015 SHALL, when stall=1 (and no exception), drive WE=0 and NPC=PC_F.
REQ-016 SHALL, when stall=0, drive WE=1 with NPC priority: br_valid target > pend_target (PEND only) > PC_F+4, using 32-bit wrap-around addition.
REQ-017 SHALL force NPC[1:0]=2'b00 for every redirect target.
REQ-018 SHALL return from PEND to RUN on any cycle with WE=1, including the case where a simultaneous br_valid supersedes the buffer.
REQ-019 SHALL derive NPC and WE combinationally from the current state and inputs, giving zero-cycle latency to the fetch unit.
REQ-020 SHALL increment fetch_cnt on every cycle with WE=1, wrapping from 0xFFFF_FFFF to 0.
REQ-021 SHALL drive pend_valid=1 exactly when the state is PEND.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, set the state to RUN, pend_target=0x0000_0000 and fetch_cnt=0, overriding all other inputs that cycle.
REQ-023 SHALL, during a reset cycle, drive outputs combinationally from the pre-reset state; from the first cycle after reset, pend_valid=0 and fetch_cnt=0.
REQ-024 SHALL discard a buffered redirect when reset is asserted mid-operation (PEND).

Configuration
REQ-025 SHALL, with FETCH_EXC_EN defined, add exc_req, which has top priority: it drives NPC=0x0000_4180 and WE=1 regardless of stall, clears any pending redirect (returns to RUN) and increments fetch_cnt.
REQ-026 SHALL, without FETCH_EXC_EN, omit exc_req and all exception logic; the handler address is unused.

Structure
REQ-027 SHALL place the following in the shared Define.v include: the state encodings (RUN=1'b0, PEND=1'b1), the text base (0x0000_3000), the handler address (0x0000_4180) and the PC step (4).
REQ-028 SHALL be a single module with no sub-modules; the NPC priority mux stays inline.

Verification
REQ-029 SHALL cover: reset, then 3 free-running cycles from PC_F=0x3000 -> NPC=0x3004, then 0x3008 and 0x300C, WE=1 each cycle, fetch_cnt=3.
REQ-030 SHALL cover: stall=1 with br_valid=1 and br_target=0x3040 for one cycle, then stall held 2 more cycles -> WE=0, NPC=PC_F, pend_valid=1; on stall release, NPC=0x3040, then pend_valid=0.
REQ-031 SHALL cover: in PEND (target 0x3040), stall=0 with br_valid=1 and br_target=0x3100 -> NPC=0x3100, and PEND is cleared.
REQ-032 SHALL cover: br_target=0x3043 -> NPC=0x3040; PC_F=0xFFFF_FFFC free-running -> NPC=0x0000_0000.
REQ-033 SHALL cover: in PEND, assert reset -> next cycle pend_valid=0 and fetch_cnt=0; release stall -> NPC=PC_F+4.
REQ-034 SHALL cover, with FETCH_EXC_EN: stall=1, PEND, exc_req=1 -> NPC=0x4180, WE=1, and pend_valid=0 on the next cycle.

Source files
------------

// File: rtl/f_fetch_ctrl_pkg.sv
// f_fetch_ctrl_pkg: shared state encodings and fetch address constants
package f_fetch_ctrl_pkg;
  localparam logic        RUN          = 1'b0;
  localparam logic        PEND         = 1'b1;
  localparam logic [31:0] TEXT_BASE    = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] PC_STEP      = 32'd4;
endpackage

// File: rtl/f_fetch_ctrl.sv
// f_fetch_ctrl: next-PC selection with a buffered redirect held across F-stage stalls
// Optional exception redirect (exc_req, top priority) enabled by defining FETCH_EXC_EN.
module f_fetch_ctrl
  import f_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_F,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
`ifdef FETCH_EXC_EN
  input  logic        exc_req,
`endif
  output logic [31:0] NPC,
  output logic        WE,
  output logic        pend_valid,
  output logic [31:0] fetch_cnt
);
  logic        state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] br_aligned;
  always_comb begin
    br_aligned    = {br_target[31:2], 2'b00};
    WE            = !stall;
    NPC           = stall ? PC_F :
                    br_valid ? br_aligned :
                    (state_q == PEND) ? pend_target_q : PC_F + PC_STEP;
    state_d       = WE ? RUN : (br_valid ? PEND : state_q);
    pend_target_d = (stall && br_valid) ? br_aligned : pend_target_q;
`ifdef FETCH_EXC_EN
    if (exc_req) begin
      NPC           = HANDLER_ADDR;
      WE            = 1'b1;
      state_d       = RUN;
      pend_target_d = pend_target_q;
    end
`endif
    fetch_cnt_d   = fetch_cnt_q + 32'(WE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pend_target_q <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end
  assign pend_valid = (state_q == PEND);
  assign fetch_cnt  = fetch_cnt_q;
endmodule
